// File: rtl/soc_system_pio_instr_queue.sv
// Avalon-MM instruction queue: HPS pushes words into a DEPTH-entry FIFO that drains to a valid/ready stream.
// Optional interrupt (drained/overflow) enabled by defining SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN.
module soc_system_pio_instr_queue #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         overflow, enable;
  logic [CNT_W-1:0]             issued;

  logic wr, push_req, flush, fire, full, empty, push_ok, ovf_set;

  assign wr       = chipselect & ~write_n;
  assign push_req = wr & (address == 2'd0);
  assign flush    = wr & (address == 2'd1) & writedata[0];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign out_valid = enable & ~empty;
  assign fire     = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign push_ok  = push_req & ~flush & (~full | fire);
  assign ovf_set  = push_req & ~flush & full & ~fire;
  assign out_port = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= writedata[DATA_W-1:0];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(fire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      enable   <= 1'b1;
      issued   <= '0;
    end else begin
      if (ovf_set) overflow <= 1'b1;
      else if (wr && address == 2'd1 && writedata[1]) overflow <= 1'b0;
      if (wr && address == 2'd2) enable <= writedata[0];
      // Software clear wins over a concurrent handshake.
      if (wr && address == 2'd3) issued <= '0;
      else if (fire)             issued <= issued + 1'b1;
    end
  end

`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
  logic drained, irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drained <= 1'b0;
      irq_en  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (fire && count == CW'(1) && !push_ok) drained <= 1'b1;
      else if (wr && address == 2'd1 && writedata[2]) drained <= 1'b0;
      if (wr && address == 2'd2) irq_en <= writedata[1];
      irq <= irq_en & (drained | overflow);
    end
  end
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[DATA_W-1:0] = out_port;
      2'd1: begin
        readdata[16 +: CW] = count;
        readdata[1]        = overflow;
        readdata[0]        = full;
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
        readdata[2]        = drained;
`endif
      end
      2'd2: begin
        readdata[0] = enable;
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
        readdata[1] = irq_en;
`endif
      end
      default: readdata[CNT_W-1:0] = issued;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_soc_system_pio_instr_queue.sv
// Directed bench for soc_system_pio_instr_queue; a second instance with CNT_W=4 follows the same bus to check counter wrap.
module tb_soc_system_pio_instr_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n, out_ready;
  logic [31:0] writedata, readdata, readdata4;
  logic [2:0]  out_port, out_port4;
  logic        out_valid, out_valid4;
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
  logic        irq, irq4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soc_system_pio_instr_queue #(.DATA_W(3), .DEPTH(4), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
    , .irq(irq)
`endif
  );

  soc_system_pio_instr_queue #(.DATA_W(3), .DEPTH(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata4),
    .out_port(out_port4), .out_valid(out_valid4), .out_ready(out_ready)
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
    , .irq(irq4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d4);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata; d4 = readdata4;
    chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, rd4;
    logic [2:0]  exp_seq [4];
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    bus_rd(2'd0, rd, rd4); chk("rst_head", rd, 32'h0);
    bus_rd(2'd1, rd, rd4); chk("rst_status", rd, 32'h0);
    bus_rd(2'd2, rd, rd4); chk("rst_ctrl", rd, 32'h1);
    bus_rd(2'd3, rd, rd4); chk("rst_issued", rd, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_port", {29'b0, out_port}, 32'h0);
    chk("rst_valid4", {28'b0, out_valid4, out_port4}, 32'h0);
`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
    chk("rst_irq", {31'b0, irq}, 32'h0);
`endif

    // Fill past full with consumer stalled
    bus_wr(2'd0, 32'd1);
    chk("lat_valid", {31'b0, out_valid}, 32'h1);
    chk("lat_port", {29'b0, out_port}, 32'h1);
    for (int i = 2; i <= 5; i++) bus_wr(2'd0, i);
    bus_rd(2'd1, rd, rd4); chk("full_status", rd, 32'h0004_0003);
    bus_rd(2'd0, rd, rd4); chk("full_head", rd, 32'h1);

    // Drain back-to-back
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_port", {29'b0, out_port}, i);
      tick();
    end
    chk("drain_empty", {31'b0, out_valid}, 32'h0);
    bus_rd(2'd3, rd, rd4); chk("drain_issued", rd, 32'd4);

    // Stream disabled: pushes land, nothing pops
    bus_wr(2'd1, 32'h6);
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd0, 32'd6);
    chk("dis_valid", {31'b0, out_valid}, 32'h0);
    chk("dis_port", {29'b0, out_port}, 32'd6);
    tick();
    bus_rd(2'd1, rd, rd4); chk("dis_status", rd & ~32'h4, 32'h0001_0000);
    bus_wr(2'd2, 32'h1);
    chk("en_valid", {31'b0, out_valid}, 32'h1);
    chk("en_port", {29'b0, out_port}, 32'd6);
    tick();
    chk("en_popped", {31'b0, out_valid}, 32'h0);
    bus_rd(2'd3, rd, rd4); chk("en_issued", rd, 32'd5);

    // Push onto full FIFO concurrently with a fire
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus_wr(2'd0, i);
    out_ready = 1'b1;
    bus_wr(2'd0, 32'd7);
    out_ready = 1'b0;
    bus_rd(2'd1, rd, rd4); chk("pf_status", rd & ~32'h4, 32'h0004_0001);
    exp_seq[0] = 3'd2; exp_seq[1] = 3'd3; exp_seq[2] = 3'd4; exp_seq[3] = 3'd7;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pf_order", {29'b0, out_port}, {29'b0, exp_seq[i]});
      tick();
    end
    out_ready = 1'b0;
    bus_rd(2'd3, rd, rd4); chk("pf_issued", rd, 32'd10);

    // Flush
    bus_wr(2'd0, 32'd1);
    bus_wr(2'd0, 32'd2);
    bus_rd(2'd1, rd, rd4); chk("fl_pre", rd & ~32'h4, 32'h0002_0000);
    bus_wr(2'd1, 32'h1);
    bus_rd(2'd1, rd, rd4); chk("fl_status", rd & ~32'h4, 32'h0);
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    // Flush concurrent with fire still counts the handshake
    bus_wr(2'd0, 32'd3);
    bus_wr(2'd0, 32'd4);
    out_ready = 1'b1;
    bus_wr(2'd1, 32'h1);
    out_ready = 1'b0;
    bus_rd(2'd1, rd, rd4); chk("flf_status", rd & ~32'h4, 32'h0);
    bus_rd(2'd3, rd, rd4);
    chk("flf_issued", rd, 32'd11);
    chk("flf_issued4", rd4, 32'd11);

    // Clear counter, then 16 streaming handshakes (push and pop overlap)
    bus_wr(2'd3, 32'hdead);
    bus_rd(2'd3, rd, rd4); chk("clr_issued", rd, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_wr(2'd0, i & 7);
      chk("stream_port", {29'b0, out_port}, i & 7);
    end
    tick();
    out_ready = 1'b0;
    bus_rd(2'd3, rd, rd4);
    chk("wrap_issued16", rd, 32'd16);
    chk("wrap_issued4", rd4, 32'd0);
    bus_rd(2'd1, rd, rd4); chk("stream_status", rd & ~32'h4, 32'h0);

`ifdef SOC_SYSTEM_PIO_INSTR_QUEUE_IRQ_EN
    bus_wr(2'd2, 32'h3);
    bus_wr(2'd1, 32'h6);
    tick(); tick();
    chk("irq_idle", {31'b0, irq}, 32'h0);
    bus_wr(2'd0, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick(); tick();
    chk("irq_drained", {31'b0, irq}, 32'h1);
    bus_rd(2'd1, rd, rd4); chk("irq_status", rd, 32'h4);
    bus_wr(2'd1, 32'h4);
    tick(); tick();
    chk("irq_clr", {31'b0, irq}, 32'h0);
`endif

    // Reset mid-stream
    bus_wr(2'd0, 32'd5);
    chk("mid_valid", {31'b0, out_valid}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_port", {29'b0, out_port}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    bus_rd(2'd1, rd, rd4); chk("mid_status", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
